// File: rtl/down_count_load_t_ff.sv
// Loadable down counter with a registered terminal-count strobe, one-shot or periodic.
// Counter bits are toggle-enabled flops: every edge applies a toggle mask to r_q.
module down_count_load_t_ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reloadNext;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_decToggle;
    logic             r_mode;
    logic             w_modeNext;
    logic             r_tc;
    logic             w_tcNext;
    logic             w_borrow;
    logic             w_loadOk;
    logic             w_qIsOne;

    assign w_loadOk = start && (load_val != '0);
    assign w_qIsOne = (r_q == WIDTH'(1));

    // A decrement toggles bit i exactly when every lower bit is zero.
    always_comb begin
        w_decToggle = '0;
        w_borrow    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_decToggle[i] = w_borrow;
            w_borrow       = w_borrow & ~r_q[i];
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_toggle     = '0;
        w_tcNext     = 1'b0;
        w_reloadNext = r_reload;
        w_modeNext   = r_mode;
        if (abort) begin
            w_stateNext = IDLE;
            w_toggle    = r_q;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_loadOk) begin
                        w_toggle     = r_q ^ load_val;
                        w_reloadNext = load_val;
                        w_modeNext   = mode;
                        w_stateNext  = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (w_qIsOne) begin
                            w_tcNext = 1'b1;
                            if (r_mode) begin
                                w_toggle = r_q ^ r_reload;
                            end else begin
                                w_toggle    = r_q;
                                w_stateNext = DONE;
                            end
                        end else begin
                            w_toggle = w_decToggle;
                        end
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_toggle    = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_q      <= r_q ^ w_toggle;
            r_reload <= w_reloadNext;
            r_mode   <= w_modeNext;
            r_tc     <= w_tcNext;
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule
